// File: rtl/sram_1rw1r_fifo_ctrl_pkg.sv
// sram_fifo_pkg: shared constants, types and helpers for the SRAM-backed
// streaming FIFO controller (sram_1rw1r_fifo_ctrl) and its prefetch stage.
//   DATA_W : word width, equal to the macro BITS
//   DEPTH  : number of SRAM words (need not be a power of two)
//   ADDR_W : SRAM address width, 2**ADDR_W >= DEPTH
package sram_fifo_pkg;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 384;
    localparam int ADDR_W = 9;

    typedef logic [ADDR_W-1:0] sram_addr_t;
    typedef logic [ADDR_W:0]   cnt_t;

    // Pointers wrap at DEPTH-1, not at the natural 2**ADDR_W-1 boundary.
    function automatic sram_addr_t ptr_inc(input sram_addr_t ptr);
        if (ptr == sram_addr_t'(DEPTH - 1)) begin
            return '0;
        end
        return ptr + sram_addr_t'(1);
    endfunction

endpackage

// File: rtl/sram_1rw1r_fifo_ctrl_prefetch.sv
// sram_fifo_prefetch: 2-entry register FIFO that receives words returning
// from the SRAM read port and presents them on the read-side stream.
// Optional feature macro: SRAM_FIFO_FLUSH_EN adds the synchronous flush input.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   flush       : (SRAM_FIFO_FLUSH_EN only) drop all held entries
//   push        : push_data is written this edge (caller guarantees room)
//   push_data   : word returning from the SRAM
//   m_ready     : read-side ready
//   m_valid     : head entry is valid
//   m_data      : head entry, straight from a register
//   pf_cnt      : entries held (0..2)
module sram_fifo_prefetch
    import sram_fifo_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
`ifdef SRAM_FIFO_FLUSH_EN
    input  logic              flush,
`endif
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              m_ready,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    output logic [1:0]        pf_cnt
);

    logic [1:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] e0_q, e0_d;
    logic [DATA_W-1:0] e1_q, e1_d;
    logic              pop;

    assign m_valid = (cnt_q != 2'd0);
    assign m_data  = e0_q;
    assign pf_cnt  = cnt_q;
    assign pop     = m_valid && m_ready;

    always_comb begin
        cnt_d = cnt_q;
        e0_d  = e0_q;
        e1_d  = e1_q;
        case ({push, pop})
            2'b10: begin
                if (cnt_q == 2'd0) e0_d = push_data;
                else               e1_d = push_data;
                cnt_d = cnt_q + 2'd1;
            end
            2'b01: begin
                if (cnt_q == 2'd2) e0_d = e1_q;
                cnt_d = cnt_q - 2'd1;
            end
            2'b11: begin
                // Count stays; the new word lands behind whatever remains.
                if (cnt_q == 2'd1) begin
                    e0_d = push_data;
                end else begin
                    e0_d = e1_q;
                    e1_d = push_data;
                end
            end
            default: ;
        endcase
`ifdef SRAM_FIFO_FLUSH_EN
        if (flush) cnt_d = 2'd0;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 2'd0;
            e0_q  <= '0;
            e1_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            e0_q  <= e0_d;
            e1_q  <= e1_d;
        end
    end

endmodule

// File: rtl/sram_1rw1r_fifo_ctrl.sv
// sram_1rw1r_fifo_ctrl: turns a 1rw1r SRAM macro (DATA_W x DEPTH) into a
// streaming FIFO. rw0 is used for writes only, r0 for reads only; the macro's
// 1-cycle read latency is absorbed by a 2-entry prefetch stage.
// Optional feature macro: SRAM_FIFO_FLUSH_EN adds a synchronous, active-high
// flush input that empties the FIFO.
// Handshake: both stream sides use valid/ready; a word transfers on a rising
// clk edge where valid and ready are both high; valid never waits on ready.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   flush               : (SRAM_FIFO_FLUSH_EN only) clear the FIFO
//   s_valid/s_ready/s_data : write-side stream
//   m_valid/m_ready/m_data : read-side stream
//   level               : words held (SRAM + in-flight read + prefetch)
//   rw0_*_out           : macro write port controls/data
//   r0_ce_out/r0_addr_out, r0_rd_in : macro read port
module sram_1rw1r_fifo_ctrl
    import sram_fifo_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
`ifdef SRAM_FIFO_FLUSH_EN
    input  logic              flush,
`endif
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic [ADDR_W:0]   level,
    output logic              rw0_ce_out,
    output logic              rw0_we_out,
    output logic [ADDR_W-1:0] rw0_addr_out,
    output logic [DATA_W-1:0] rw0_wd_out,
    output logic              r0_ce_out,
    output logic [ADDR_W-1:0] r0_addr_out,
    input  logic [DATA_W-1:0] r0_rd_in
);

    sram_addr_t        wr_ptr_q, wr_ptr_d;
    sram_addr_t        rd_ptr_q, rd_ptr_d;
    cnt_t              sram_cnt_q, sram_cnt_d;
    logic              inflight_q, inflight_d;
    logic              s_ready_q, s_ready_d;
    sram_addr_t        wr_addr_hold_q, wr_addr_hold_d;
    logic [DATA_W-1:0] wr_data_hold_q, wr_data_hold_d;

    logic       push;
    logic       fetch;
    logic       capture;
    logic       flush_now;
    logic [1:0] pf_cnt;
    logic [2:0] pf_busy;

`ifdef SRAM_FIFO_FLUSH_EN
    assign flush_now = flush;
`else
    assign flush_now = 1'b0;
`endif

    assign push    = s_valid && s_ready_q;
    assign pf_busy = {1'b0, pf_cnt} + {2'b00, inflight_q};
    // Only fetch when the prefetch stage is guaranteed room for the word.
    assign fetch   = (sram_cnt_q != '0) && (pf_busy < 3'd2);
    // The read issued last edge returns now; a flush drops it.
    assign capture = inflight_q && !flush_now;

    always_comb begin
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        sram_cnt_d     = sram_cnt_q;
        wr_addr_hold_d = wr_addr_hold_q;
        wr_data_hold_d = wr_data_hold_q;
        inflight_d     = fetch;
        if (push) begin
            wr_ptr_d       = ptr_inc(wr_ptr_q);
            wr_addr_hold_d = wr_ptr_q;
            wr_data_hold_d = s_data;
        end
        if (fetch) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({push, fetch})
            2'b10:   sram_cnt_d = sram_cnt_q + cnt_t'(1);
            2'b01:   sram_cnt_d = sram_cnt_q - cnt_t'(1);
            default: sram_cnt_d = sram_cnt_q;
        endcase
        if (flush_now) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            sram_cnt_d = '0;
            inflight_d = 1'b0;
        end
        s_ready_d = (sram_cnt_d < cnt_t'(DEPTH));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            sram_cnt_q     <= '0;
            inflight_q     <= 1'b0;
            s_ready_q      <= 1'b0;
            wr_addr_hold_q <= '0;
            wr_data_hold_q <= '0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            sram_cnt_q     <= sram_cnt_d;
            inflight_q     <= inflight_d;
            s_ready_q      <= s_ready_d;
            wr_addr_hold_q <= wr_addr_hold_d;
            wr_data_hold_q <= wr_data_hold_d;
        end
    end

    // Address/data hold their last driven value when idle so the macro
    // never sees an undefined address or data word.
    assign s_ready      = s_ready_q;
    assign rw0_ce_out   = push;
    assign rw0_we_out   = push;
    assign rw0_addr_out = push ? wr_ptr_q : wr_addr_hold_q;
    assign rw0_wd_out   = push ? s_data : wr_data_hold_q;
    assign r0_ce_out    = fetch;
    assign r0_addr_out  = rd_ptr_q;
    assign level        = sram_cnt_q + cnt_t'(inflight_q) + cnt_t'(pf_cnt);

    sram_fifo_prefetch u_pf (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef SRAM_FIFO_FLUSH_EN
        .flush     (flush),
`endif
        .push      (capture),
        .push_data (r0_rd_in),
        .m_ready   (m_ready),
        .m_valid   (m_valid),
        .m_data    (m_data),
        .pf_cnt    (pf_cnt)
    );

endmodule

// File: tb/tb_sram_1rw1r_fifo_ctrl.sv
// Testbench for sram_1rw1r_fifo_ctrl with a behavioural 1rw1r SRAM model.
// Optional feature macro: SRAM_FIFO_FLUSH_EN enables the flush sequence.
module tb_sram_1rw1r_fifo_ctrl;

    logic        clk;
    logic        rst_n;
`ifdef SRAM_FIFO_FLUSH_EN
    logic        flush;
`endif
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_data;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_data;
    logic [9:0]  level;
    logic        rw0_ce_out;
    logic        rw0_we_out;
    logic [8:0]  rw0_addr_out;
    logic [31:0] rw0_wd_out;
    logic        r0_ce_out;
    logic [8:0]  r0_addr_out;
    logic [31:0] r0_rd_in;

    sram_1rw1r_fifo_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
`ifdef SRAM_FIFO_FLUSH_EN
        .flush        (flush),
`endif
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_data       (s_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .level        (level),
        .rw0_ce_out   (rw0_ce_out),
        .rw0_we_out   (rw0_we_out),
        .rw0_addr_out (rw0_addr_out),
        .rw0_wd_out   (rw0_wd_out),
        .r0_ce_out    (r0_ce_out),
        .r0_addr_out  (r0_addr_out),
        .r0_rd_in     (r0_rd_in)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    // ---------------- SRAM model ----------------
    // Read data is garbage whenever the previous cycle had no fetch.
    logic [31:0] mem [0:511];
    always @(posedge clk) begin
        if (rw0_ce_out && rw0_we_out) mem[rw0_addr_out] <= rw0_wd_out;
        if (r0_ce_out) r0_rd_in <= mem[r0_addr_out];
        else           r0_rd_in <= 32'hBAD0_BAD0;
    end

    // ---------------- scoreboard ----------------
    logic [31:0] exp_q[$];
    int          total = 0;
    int          bad   = 0;
    logic [31:0] word_ctr = 32'h0000_1000;
    int          addr_err = 0;
    int          ce_full_err = 0;
    int          x_err = 0;
    int          max_addr = 0;
    int          last_wr_addr = -1;
    logic        wrap_seen = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // Invariant monitor, called at each sample point.
    task automatic monitor();
        if ($isunknown({rw0_addr_out, rw0_wd_out, rw0_we_out, rw0_ce_out, r0_addr_out, r0_ce_out}))
            x_err++;
        if (rw0_ce_out) begin
            if (int'(rw0_addr_out) > 383) addr_err++;
            if (int'(rw0_addr_out) > max_addr) max_addr = int'(rw0_addr_out);
            if (last_wr_addr == 383 && rw0_addr_out == 9'd0) wrap_seen = 1'b1;
            last_wr_addr = int'(rw0_addr_out);
        end
        if (r0_ce_out && (int'(dut.pf_cnt) + int'(dut.inflight_q) == 2)) ce_full_err++;
    endtask

    // mode 0: m_ready=1; mode 1: m_ready 1010; mode 2: random gaps both sides
    task automatic run_stream(input int n_words, input int mode);
        int pushed = 0;
        int cyc = 0;
        while ((pushed < n_words || exp_q.size() > 0) && cyc < 20000) begin
            @(negedge clk);
            s_valid = (pushed < n_words) && (mode != 2 || $urandom_range(0, 3) != 0);
            s_data  = word_ctr;
            case (mode)
                0:       m_ready = 1'b1;
                1:       m_ready = (cyc % 2 == 0);
                default: m_ready = ($urandom_range(0, 2) != 0);
            endcase
            #1;
            monitor();
            if (s_valid && s_ready) begin
                exp_q.push_back(word_ctr);
                word_ctr++;
                pushed++;
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) check("stream_extra_word", m_data, 32'hFFFF_FFFF);
                else                   check("stream_data", m_data, exp_q.pop_front());
            end
            cyc++;
        end
        s_valid = 1'b0;
        check("stream_done_in_budget", 32'(cyc < 20000), 32'd1);
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        logic        s_valid;
        logic [31:0] s_data;
        logic        m_ready;
        logic        e_s_ready;
        logic        e_m_valid;
        logic [31:0] e_m_data;
        logic [9:0]  e_level;
        logic        e_rw0_ce;
        logic [8:0]  e_rw0_addr;
        logic [31:0] e_rw0_wd;
        logic        e_r0_ce;
        logic [8:0]  e_r0_addr;
    } vec_t;

    vec_t vecs[12];

    initial begin
        int n;
        vecs[0]  = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0,        10'd0, 1'b0, 9'd0, 32'h0,        1'b0, 9'd0};
        vecs[1]  = '{1'b1, 32'hDEADBEEF, 1'b1, 1'b1, 1'b0, 32'h0,        10'd0, 1'b1, 9'd0, 32'hDEADBEEF, 1'b0, 9'd0};
        vecs[2]  = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h0,        10'd1, 1'b0, 9'd0, 32'hDEADBEEF, 1'b1, 9'd0};
        vecs[3]  = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h0,        10'd1, 1'b0, 9'd0, 32'hDEADBEEF, 1'b0, 9'd1};
        vecs[4]  = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'hDEADBEEF, 10'd1, 1'b0, 9'd0, 32'hDEADBEEF, 1'b0, 9'd1};
        vecs[5]  = '{1'b1, 32'h11111111, 1'b0, 1'b1, 1'b0, 32'h0,        10'd0, 1'b1, 9'd1, 32'h11111111, 1'b0, 9'd1};
        vecs[6]  = '{1'b1, 32'h22222222, 1'b0, 1'b1, 1'b0, 32'h0,        10'd1, 1'b1, 9'd2, 32'h22222222, 1'b1, 9'd1};
        vecs[7]  = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0,        10'd2, 1'b0, 9'd2, 32'h22222222, 1'b1, 9'd2};
        vecs[8]  = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 32'h11111111, 10'd2, 1'b0, 9'd2, 32'h22222222, 1'b0, 9'd3};
        vecs[9]  = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'h11111111, 10'd2, 1'b0, 9'd2, 32'h22222222, 1'b0, 9'd3};
        vecs[10] = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'h22222222, 10'd1, 1'b0, 9'd2, 32'h22222222, 1'b0, 9'd3};
        vecs[11] = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h0,        10'd0, 1'b0, 9'd2, 32'h22222222, 1'b0, 9'd3};

        // Reset state, with inputs active to show they are ignored.
        rst_n   = 1'b0;
`ifdef SRAM_FIFO_FLUSH_EN
        flush   = 1'b0;
`endif
        s_valid = 1'b1;
        s_data  = 32'hCAFE_F00D;
        m_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_s_ready",  32'(s_ready),    32'd0);
        check("rst_m_valid",  32'(m_valid),    32'd0);
        check("rst_m_data",   m_data,          32'd0);
        check("rst_level",    32'(level),      32'd0);
        check("rst_rw0_ce",   32'(rw0_ce_out), 32'd0);
        check("rst_rw0_we",   32'(rw0_we_out), 32'd0);
        check("rst_rw0_addr", 32'(rw0_addr_out), 32'd0);
        check("rst_rw0_wd",   rw0_wd_out,      32'd0);
        check("rst_r0_ce",    32'(r0_ce_out),  32'd0);
        check("rst_r0_addr",  32'(r0_addr_out), 32'd0);
        s_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Single word plus a two-word burst under backpressure.
        for (int i = 0; i < 12; i++) begin
            s_valid = vecs[i].s_valid;
            s_data  = vecs[i].s_data;
            m_ready = vecs[i].m_ready;
            #1;
            monitor();
            check($sformatf("v%0d_s_ready", i),  32'(s_ready),     32'(vecs[i].e_s_ready));
            check($sformatf("v%0d_m_valid", i),  32'(m_valid),     32'(vecs[i].e_m_valid));
            if (vecs[i].e_m_valid)
                check($sformatf("v%0d_m_data", i), m_data,         vecs[i].e_m_data);
            check($sformatf("v%0d_level", i),    32'(level),       32'(vecs[i].e_level));
            check($sformatf("v%0d_rw0_ce", i),   32'(rw0_ce_out),  32'(vecs[i].e_rw0_ce));
            check($sformatf("v%0d_rw0_we", i),   32'(rw0_we_out),  32'(vecs[i].e_rw0_ce));
            check($sformatf("v%0d_rw0_addr", i), 32'(rw0_addr_out), 32'(vecs[i].e_rw0_addr));
            check($sformatf("v%0d_rw0_wd", i),   rw0_wd_out,       vecs[i].e_rw0_wd);
            check($sformatf("v%0d_r0_ce", i),    32'(r0_ce_out),   32'(vecs[i].e_r0_ce));
            check($sformatf("v%0d_r0_addr", i),  32'(r0_addr_out), 32'(vecs[i].e_r0_addr));
            @(negedge clk);
        end
        s_valid = 1'b0;

        // Fill until s_ready drops: 384 in SRAM plus 2 in prefetch.
        n = 0;
        for (int c = 0; c < 600; c++) begin
            s_valid = 1'b1;
            s_data  = word_ctr;
            m_ready = 1'b0;
            #1;
            monitor();
            if (!s_ready) break;
            exp_q.push_back(word_ctr);
            word_ctr++;
            n++;
            @(negedge clk);
        end
        s_valid = 1'b0;
        check("fill_pushes", 32'(n), 32'd386);
        repeat (3) @(negedge clk);
        #1;
        check("full_level",   32'(level),   32'd386);
        check("full_s_ready", 32'(s_ready), 32'd0);
        check("full_m_valid", 32'(m_valid), 32'd1);
        // Pop one word: a fetch follows, and s_ready returns a cycle later.
        @(negedge clk);
        m_ready = 1'b1;
        #1;
        check("full_pop_data", m_data, exp_q.pop_front());
        @(negedge clk);
        m_ready = 1'b0;
        #1;
        check("refill_fetch",    32'(r0_ce_out), 32'd1);
        check("refill_s_ready0", 32'(s_ready),   32'd0);
        @(negedge clk);
        #1;
        check("refill_s_ready1", 32'(s_ready),   32'd1);
        check("refill_level",    32'(level),     32'd385);

        // Drain under 1010 backpressure while pushing every cycle,
        // then a long in-order stream, then random gaps.
        run_stream(200, 1);
        run_stream(1000, 0);
        run_stream(300, 2);
        #1;
        check("queue_empty",   32'(exp_q.size()), 32'd0);
        check("addr_in_range", 32'(addr_err),     32'd0);
        check("max_wr_addr",   32'(max_addr),     32'd383);
        check("wrap_seen",     32'(wrap_seen),    32'd1);
        check("ce_while_full", 32'(ce_full_err),  32'd0);
        check("no_x_on_macro", 32'(x_err),        32'd0);

`ifdef SRAM_FIFO_FLUSH_EN
        // Queue 5 words, pop one so a refetch is inflight, flush as it returns.
        @(negedge clk);
        m_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            s_valid = 1'b1;
            s_data  = 32'hF000_0000 + 32'(k);
            @(negedge clk);
        end
        s_valid = 1'b0;
        repeat (4) @(negedge clk);
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
        #1;
        check("flush_pre_fetch", 32'(r0_ce_out), 32'd1);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush   = 1'b0;
        s_valid = 1'b1;
        s_data  = 32'h0000_0001;
        m_ready = 1'b1;
        #1;
        check("flush_m_valid", 32'(m_valid), 32'd0);
        check("flush_level",   32'(level),   32'd0);
        check("flush_s_ready", 32'(s_ready), 32'd1);
        @(negedge clk);
        s_valid = 1'b0;
        #1;
        check("flush_e0_m_valid", 32'(m_valid), 32'd0);
        @(negedge clk);
        #1;
        check("flush_e1_m_valid", 32'(m_valid), 32'd0);
        @(negedge clk);
        #1;
        check("flush_e2_m_valid", 32'(m_valid), 32'd1);
        check("flush_first_data", m_data,       32'h0000_0001);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
